// File: rtl/ddr_pkg.sv
// Shared types for the DDR note scheduler: lane index, FSM states and note slot record.
package ddr_pkg;

  localparam int unsigned NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  typedef struct packed {
    logic       valid;
    lane_t      lane;
    logic [9:0] y;
  } slot_t;

endpackage

// File: rtl/ddr_btn_latch.sv
// Per-lane button rising-edge latch. A new edge sets pend; clear requests drop it,
// but a set in the same cycle wins so no press is ever lost.
module ddr_btn_latch
  import ddr_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] btn_i,
  input  logic [NUM_LANES-1:0] clr_i,
  output logic [NUM_LANES-1:0] pend_o
);

  logic [NUM_LANES-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;

  // Edge detect and set-over-clear pending update.
  always_comb begin
    btn_prev_d = btn_i;
    pend_d     = (pend_q & ~clr_i) | (btn_i & ~btn_prev_q);
  end

  // Button history and pending flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      pend_q     <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/ddr_note_sched.sv
// Frame-sequenced note scheduler: note table, once-per-frame scan for fall/hit/miss,
// and a registered per-pixel "note here?" query for the VGA colour mux.
// Optional feature: define DDR_NOTE_SCHED_SCORE_EN to build the saturating hit score counter.
module ddr_note_sched
  import ddr_pkg::*;
#(
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned NOTE_H   = 16,
  parameter int unsigned LANE_W   = 60,
  parameter int unsigned HIT_Y    = 400,
  parameter int unsigned HIT_WIN  = 16,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic        i_pixclk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_spawn_valid,
  input  logic [1:0]  i_spawn_lane,
  output logic        o_spawn_ready,
  input  logic [3:0]  i_btn,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic        o_note_px,
  output logic [1:0]  o_note_lane,
  output logic        o_hit_pulse,
  output logic        o_miss_pulse,
  output logic        o_busy,
  output logic [15:0] o_score
);

  localparam int unsigned IdxW = $clog2(SLOTS);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  slot_t                slot_q [SLOTS];
  slot_t                slot_d [SLOTS];
  logic                 hit_q, hit_d, miss_q, miss_d;
  logic                 px_q, px_d;
  lane_t                lane_q, lane_d;

  logic                 scan_en, done, spawn_acc, any_free;
  logic [IdxW-1:0]      free_idx;
  logic [NUM_LANES-1:0] pend, clr_mask, btn_clr;
  slot_t                cur;
  logic [10:0]          ny;
  logic                 in_win;

  ddr_btn_latch u_btn_latch (
    .clk_i  (i_pixclk),
    .rst_i  (i_rst),
    .btn_i  (i_btn),
    .clr_i  (btn_clr),
    .pend_o (pend)
  );

  // DONE wipes every pending press; a hit only consumes its own lane.
  assign btn_clr = done ? {NUM_LANES{1'b1}} : clr_mask;

  // FSM state register.
  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state: a tick starts the scan, one slot per cycle, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_frame_tick) state_d = StScan;
      StScan:  if (idx_q == IdxW'(SLOTS - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and handshake.
  always_comb begin
    scan_en       = (state_q == StScan);
    done          = (state_q == StDone);
    o_busy        = (state_q != StIdle);
    o_spawn_ready = (state_q == StIdle) && any_free;
    spawn_acc     = i_spawn_valid && o_spawn_ready;
  end

  // Lowest free slot, found by scanning downward so the lowest index is assigned last.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Slot update: fall / hit / miss for the scanned slot, or spawn write while idle.
  always_comb begin
    slot_d   = slot_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    clr_mask = '0;
    idx_d    = idx_q;
    cur      = slot_q[idx_q];
    ny       = {1'b0, cur.y} + 11'(SPEED);
    in_win   = (32'(cur.y) + HIT_WIN >= HIT_Y) && (32'(cur.y) <= HIT_Y + HIT_WIN);

    if (state_q == StIdle && i_frame_tick) idx_d = '0;
    if (scan_en) idx_d = idx_q + 1'b1;

    if (scan_en && cur.valid) begin
      if (pend[cur.lane] && in_win) begin
        slot_d[idx_q].valid = 1'b0;
        hit_d               = 1'b1;
        clr_mask[cur.lane]  = 1'b1;
      end else if (32'(ny) >= SCREEN_H) begin
        slot_d[idx_q].valid = 1'b0;
        miss_d              = 1'b1;
      end else begin
        slot_d[idx_q].y = ny[9:0];
      end
    end

    if (spawn_acc) begin
      slot_d[free_idx].valid = 1'b1;
      slot_d[free_idx].lane  = i_spawn_lane;
      slot_d[free_idx].y     = '0;
    end
  end

  // Pixel query: lowest-index valid note covering (i_x, i_y).
  always_comb begin
    px_d   = 1'b0;
    lane_d = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (slot_q[i].valid &&
          32'(i_x) >= LANE_W * 32'(slot_q[i].lane) &&
          32'(i_x) <  LANE_W * (32'(slot_q[i].lane) + 1) &&
          32'(i_y) >= 32'(slot_q[i].y) &&
          32'(i_y) <  32'(slot_q[i].y) + NOTE_H) begin
        px_d   = 1'b1;
        lane_d = slot_q[i].lane;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(SLOTS); i++) slot_q[i] <= '0;
      idx_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      px_q   <= 1'b0;
      lane_q <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
      px_q   <= px_d;
      lane_q <= lane_d;
    end
  end

  assign o_hit_pulse  = hit_q;
  assign o_miss_pulse = miss_q;
  assign o_note_px    = px_q;
  assign o_note_lane  = lane_q;

`ifdef DDR_NOTE_SCHED_SCORE_EN
  logic [15:0] score_q, score_d;

  // Saturating hit counter.
  always_comb begin
    score_d = score_q;
    if (hit_q && score_q != 16'hFFFF) score_d = score_q + 16'd1;
  end

  // Score register.
  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) score_q <= '0;
    else       score_q <= score_d;
  end

  assign o_score = score_q;
`else
  assign o_score = '0;
`endif

endmodule

// File: tb/tb_ddr_note_sched.sv
// Self-checking bench for ddr_note_sched: directed scenarios plus random frames,
// all checked against a frame-level behavioural model of the note table.
module tb_ddr_note_sched;

  localparam int NSLOT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [1:0]  spawn_lane = '0;
  logic        spawn_ready;
  logic [3:0]  btn = '0;
  logic [9:0]  qx = '0;
  logic [9:0]  qy = '0;
  logic        note_px;
  logic [1:0]  note_lane;
  logic        hit_pulse, miss_pulse, busy;
  logic [15:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_valid [NSLOT];
  int m_lane  [NSLOT];
  int m_y     [NSLOT];
  bit m_pend  [4];
  int m_score;

  ddr_note_sched dut (
    .i_pixclk      (clk),
    .i_rst         (rst),
    .i_frame_tick  (tick),
    .i_spawn_valid (spawn_valid),
    .i_spawn_lane  (spawn_lane),
    .o_spawn_ready (spawn_ready),
    .i_btn         (btn),
    .i_x           (qx),
    .i_y           (qy),
    .o_note_px     (note_px),
    .o_note_lane   (note_lane),
    .o_hit_pulse   (hit_pulse),
    .o_miss_pulse  (miss_pulse),
    .o_busy        (busy),
    .o_score       (score)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_free();
    for (int i = 0; i < NSLOT; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int exp_score();
`ifdef DDR_NOTE_SCHED_SCORE_EN
    return m_score;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSLOT; i++) begin
      m_valid[i] = 0; m_lane[i] = 0; m_y[i] = 0;
    end
    for (int k = 0; k < 4; k++) m_pend[k] = 0;
    m_score = 0;
  endtask

  task automatic do_reset();
    btn = '0; tick = 0; spawn_valid = 0;
    rst = 1;
    step();
    rst = 0;
    step();
    model_clear();
  endtask

  task automatic set_btn(input logic [3:0] nb);
    for (int k = 0; k < 4; k++) if (nb[k] && !btn[k]) m_pend[k] = 1;
    btn = nb;
    step();
  endtask

  task automatic spawn(input int lane);
    int f;
    f = model_free();
    spawn_valid = 1; spawn_lane = 2'(lane);
    chk("spawn_ready", {31'd0, spawn_ready}, (f >= 0) ? 1 : 0);
    step();
    spawn_valid = 0;
    if (f >= 0) begin
      m_valid[f] = 1; m_lane[f] = lane; m_y[f] = 0;
    end
  endtask

  // One full frame: optional same-cycle spawn, tick, per-slot pulse checks, busy, score.
  task automatic frame(input bit with_spawn, input int lane);
    bit eh [NSLOT];
    bit em [NSLOT];
    int f, d;
    f = -1;
    if (with_spawn) begin
      f = model_free();
      spawn_valid = 1; spawn_lane = 2'(lane);
      chk("tick_ready", {31'd0, spawn_ready}, (f >= 0) ? 1 : 0);
    end
    tick = 1;
    step();
    tick = 0; spawn_valid = 0;
    if (f >= 0) begin
      m_valid[f] = 1; m_lane[f] = lane; m_y[f] = 0;
    end
    chk("busy_start", {31'd0, busy}, 1);
    for (int i = 0; i < NSLOT; i++) begin
      eh[i] = 0; em[i] = 0;
      if (m_valid[i]) begin
        d = m_y[i] - 400;
        if (d < 0) d = -d;
        if (m_pend[m_lane[i]] && d <= 16) begin
          eh[i] = 1; m_valid[i] = 0; m_pend[m_lane[i]] = 0;
          if (m_score < 65535) m_score++;
        end else if (m_y[i] + 2 >= 480) begin
          em[i] = 1; m_valid[i] = 0;
        end else begin
          m_y[i] += 2;
        end
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      step();
      chk($sformatf("hit_s%0d", i), {31'd0, hit_pulse}, {31'd0, eh[i]});
      chk($sformatf("miss_s%0d", i), {31'd0, miss_pulse}, {31'd0, em[i]});
    end
    chk("busy_done", {31'd0, busy}, 1);
    for (int k = 0; k < 4; k++) m_pend[k] = 0;
    step();
    chk("busy_idle", {31'd0, busy}, 0);
    chk("score", {16'd0, score}, exp_score());
  endtask

  task automatic frames(input int n);
    for (int j = 0; j < n; j++) frame(0, 0);
  endtask

  task automatic query(input int x, input int y);
    int el, ep;
    qx = 10'(x); qy = 10'(y);
    step();
    ep = 0; el = 0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m_valid[i] && x >= m_lane[i] * 60 && x < m_lane[i] * 60 + 60 &&
          y >= m_y[i] && y < m_y[i] + 16) begin
        ep = 1; el = m_lane[i];
      end
    end
    chk($sformatf("px(%0d,%0d)", x, y), {31'd0, note_px}, ep);
    chk($sformatf("lane(%0d,%0d)", x, y), {30'd0, note_lane}, el);
  endtask

  initial begin
    model_clear();
    rst = 1;
    #5;
    chk("rst_px", {31'd0, note_px}, 0);
    chk("rst_hit", {31'd0, hit_pulse}, 0);
    chk("rst_miss", {31'd0, miss_pulse}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_score", {16'd0, score}, 0);
    do_reset();
    chk("rst_ready", {31'd0, spawn_ready}, 1);

    // Pixel query on a lane-3 note at y=100.
    spawn(3);
    frames(50);
    query(200, 105);
    query(200, 116);
    query(200, 100);
    query(179, 105);

    // Slot 1 older than slot 0: slot 0 at 392, slot 1 at 410, one lane-0 press.
    do_reset();
    spawn(3);
    frames(231);
    spawn(0);
    frames(9);
    spawn(0);
    frames(196);
    query(30, 392);
    query(30, 410);
    set_btn(4'b0001);
    frame(0, 0);
    set_btn(4'b0000);
    query(30, 412);
    query(30, 411);
    query(30, 393);

    // Lane-1 hit at exactly y=400.
    do_reset();
    spawn(1);
    frames(200);
    set_btn(4'b0010);
    frame(0, 0);
    set_btn(4'b0000);

    // Fill the table, see ready drop, then a miss frees slot 0 for the next spawn.
    do_reset();
    for (int j = 0; j < NSLOT; j++) begin
      spawn(2);
      frame(0, 0);
    end
    spawn(1);
    frames(233);
    spawn(1);
    query(70, 0);
    query(130, 4);

    // Reset in the middle of a scan with notes about to miss.
    do_reset();
    spawn(0); spawn(1); spawn(2); spawn(3); spawn(0);
    frames(239);
    tick = 1;
    step();
    tick = 0;
    step(); step(); step();
    rst = 1;
    #1;
    chk("mid_rst_px", {31'd0, note_px}, 0);
    chk("mid_rst_hit", {31'd0, hit_pulse}, 0);
    chk("mid_rst_miss", {31'd0, miss_pulse}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_score", {16'd0, score}, 0);
    model_clear();
    step();
    rst = 0;
    frame(0, 0);
    query(10, 0);

    // Random frames: random presses, spawns (some on the tick cycle) and queries.
    for (int it = 0; it < 300; it++) begin
      int j;
      if ($urandom_range(0, 2) == 0) set_btn(4'($urandom));
      if ($urandom_range(0, 3) == 0) spawn(int'($urandom_range(0, 3)));
      j = int'($urandom_range(0, NSLOT - 1));
      if (m_valid[j]) query(m_lane[j] * 60 + int'($urandom_range(0, 59)),
                            m_y[j] + int'($urandom_range(0, 17)));
      query(int'($urandom_range(0, 250)), int'($urandom_range(0, 490)));
      frame(bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
